imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shares the single immediate sign-extension datapath (5-bit field to 8-bit operand) between the two decode-side consumers of immediates: the ALU immediate path (requester 0) and the branch-offset path (requester 1). Each cycle it accepts at most one request, extends it, and holds the result in a single-entry output register until the execute stage takes it. It sits between the instruction decoder and the operand mux, and replaces the two private extenders that would otherwise be instantiated.

## Interface
- IN_W, default 5: immediate field width.
- OUT_W, default 8: extended operand width; must satisfy OUT_W > IN_W.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 (ALU immediate) has an immediate.
- req0_imm  in  IN_W  requester 0 immediate field.
- req0_zext  in  1  1 = zero-extend, 0 = sign-extend.
- req0_ready  out  1  request 0 accepted this cycle (grant).
- req1_valid, req1_imm, req1_zext, req1_ready: same as above, for requester 1 (branch offset).
- out_valid  out  1  out_data holds an unconsumed result.
- out_data  out  OUT_W  extended immediate.
- out_id  out  1  requester that produced out_data (0 or 1).
- out_ready  in  1  consumer takes out_data this cycle when out_valid=1.

## Operation
- Output register states: EMPTY (out_valid=0) or FULL (out_valid=1).
- can_accept = EMPTY, or (FULL and out_ready).
- Grant: at most one of req0_ready/req1_ready is high per cycle. reqN_ready=1 only if can_accept, reqN_valid=1 and N wins arbitration. readies are combinational from the valids, out_ready and state. No combinational path from reqN_imm to any ready.
- Arbitration with both valid: round-robin. A 1-bit last_grant register flips to the winner on every grant. The requester other than last_grant wins. last_grant resets to 1, so requester 0 wins the first contest.
- Single valid requester: wins regardless of last_grant.
- Extension: for bits [IN_W-1:0], out_data = imm. Bits [OUT_W-1:IN_W] are filled with zeros if zext=1, otherwise with copies of imm[IN_W-1].
- On a grant, out_data, out_id and out_valid=1 load at the next edge.
- FULL, out_ready=1, no grant: next state EMPTY.
- FULL, out_ready=1, grant: stays FULL with the new data (back-to-back, no bubble).
- FULL, out_ready=0: all registers hold; no grants.
- Requesters must hold valid, imm and zext stable until ready. A request withdrawn before its grant is legal and is simply not served.
- reset_n low, at any time including mid-transfer: out_valid=0, out_data=0, out_id=0, last_grant=1, all readies 0 immediately. A result that was pending is discarded.

## Timing
- Latency: 1 cycle from grant edge to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- Reset values: out_valid=0, out_data=8'h00, out_id=0, req0_ready=0, req1_ready=0.
- Reset release: a grant can occur in the first cycle reset_n is sampled high.
- Under sustained dual requests with out_ready=1, grants alternate 0,1,0,1...
- Starvation bound: a waiting requester is granted within 2 accepting cycles.

## Configuration
- IMM_EXT_RR_EN defined: round-robin arbitration as described above.
- IMM_EXT_RR_EN undefined: fixed priority, requester 0 always wins a contest. last_grant is not implemented. Requester 1 may starve and is served only when req0_valid=0.
- All other behaviour is identical in both builds.

## Test plan
- Reset / single sign-extend: reset_n low then high; req0 imm=5'b10110, zext=0 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=8'hF6, out_id=0. Assert reset_n mid-hold -> out_valid=0, out_data=8'h00 with no clock edge.
- Zero-extend and positive: req1 imm=5'b10110, zext=1 -> out_data=8'h16, out_id=1. req0 imm=5'b01111, zext=0 -> out_data=8'h0F.
- Contention, round-robin: both valid every cycle with out_ready=1, req0 imm=5'h1F, req1 imm=5'h01 -> out_id sequence 0,1,0,1 and out_data sequence FF,01,FF,01. With IMM_EXT_RR_EN undefined -> out_id is always 0.
- Backpressure: out FULL with 8'hF6, out_ready=0 for 3 cycles while req1 is valid -> req1_ready=0 and out_data holds F6. Raise out_ready -> req1 is granted the same cycle, and the new data appears next cycle with no empty cycle in between.
- Drain without refill: FULL, out_ready=1, no valids -> next cycle out_valid=0, and last_grant is unchanged.
- Boundary values: sweep all 32 imm values × zext for both requesters against the reference model -> out_data is correct for each, including 5'h10 to 8'hF0 (sext) and 8'h10 (zext).

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
// Shares one immediate extender (IN_W-bit field to OUT_W-bit operand) between
// the ALU immediate path (requester 0) and the branch-offset path
// (requester 1). At most one request is accepted per cycle, extended, and
// held in a single-entry output register until the execute stage takes it.
//
// Build option:
//   IMM_EXT_RR_EN defined   -> round-robin between the two requesters,
//                              tracked by a 1-bit last_grant register.
//   IMM_EXT_RR_EN undefined -> fixed priority, requester 0 always wins.
//
// OUT_W must be strictly greater than IN_W.
module imm_ext_arbiter #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_imm,
    input  logic             req0_zext,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_imm,
    input  logic             req1_zext,
    output logic             req1_ready,

    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready
);

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [OUT_W-1:0] data_reg;
    logic [OUT_W-1:0] data_next;
    logic             id_reg;
    logic             id_next;

    logic             can_accept;
    logic             win0;
    logic             win1;
    logic             grant0;
    logic             grant1;
    logic             any_grant;

    logic [IN_W-1:0]  sel_imm;
    logic             sel_zext;
    logic             fill_bit;
    logic [OUT_W-1:0] ext_value;

    // The register can take a new result when it is empty, or when the
    // current result leaves this same cycle (back-to-back without a bubble).
    assign can_accept = (state_reg == EMPTY) || out_ready;

`ifdef IMM_EXT_RR_EN
    logic last_grant_reg;
    logic last_grant_next;

    // Round-robin: a lone requester always wins; in a contest the requester
    // that was not granted last time wins.
    always_comb begin
        win0 = req0_valid && (!req1_valid || last_grant_reg);
        win1 = req1_valid && (!req0_valid || !last_grant_reg);
    end

    // last_grant follows the winner of every grant and holds otherwise.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (grant0) begin
            last_grant_next = 1'b0;
        end else if (grant1) begin
            last_grant_next = 1'b1;
        end
    end

    // Reset value 1 makes requester 0 the winner of the first contest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    // Fixed priority: requester 1 is served only while requester 0 is idle.
    always_comb begin
        win0 = req0_valid;
        win1 = req1_valid && !req0_valid;
    end
`endif

    // Grants depend only on valids, out_ready, state and reset; the immediate
    // fields never reach the ready outputs. Reset forces readies low at once,
    // without waiting for a clock edge.
    always_comb begin
        grant0    = reset_n && can_accept && win0;
        grant1    = reset_n && can_accept && win1;
        any_grant = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the winning requester's field into the shared extender.
    always_comb begin
        sel_imm  = req0_imm;
        sel_zext = req0_zext;
        if (grant1) begin
            sel_imm  = req1_imm;
            sel_zext = req1_zext;
        end
    end

    // Low bits pass straight through; every upper bit is either zero or a
    // copy of the field's sign bit.
    assign fill_bit                = !sel_zext && sel_imm[IN_W-1];
    assign ext_value[IN_W-1:0]     = sel_imm;

    genvar gi;
    generate
        for (gi = IN_W; gi < OUT_W; gi++) begin : g_fill
            assign ext_value[gi] = fill_bit;
        end
    endgenerate

    // Output register next state: load on a grant, drain when the consumer
    // takes the result with nothing new arriving, otherwise hold.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        id_next    = id_reg;
        if (any_grant) begin
            state_next = FULL;
            data_next  = ext_value;
            id_next    = grant1;
        end else if ((state_reg == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Output register; a pending result is discarded by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            id_reg    <= id_next;
        end
    end

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_id    = id_reg;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter (IN_W=5, OUT_W=8). Expected results
// are pushed to a scoreboard queue when a grant is predicted and compared
// while the DUT presents them. Contest expectations follow IMM_EXT_RR_EN.
module tb_imm_ext_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0_valid;
    logic [4:0] req0_imm;
    logic       req0_zext;
    logic       req0_ready;
    logic       req1_valid;
    logic [4:0] req1_imm;
    logic       req1_zext;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;

    int passed;
    int total;

    typedef struct {
        logic [7:0] d;
        logic       id;
    } exp_t;

    exp_t exp_q[$];
    logic m_last;

    imm_ext_arbiter #(.IN_W(5), .OUT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_imm   (req0_imm),
        .req0_zext  (req0_zext),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_imm   (req1_imm),
        .req1_zext  (req1_zext),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension computed arithmetically: a negative 5-bit value
    // v (>= 16) maps to v - 32 + 256 when sign-extended into 8 bits.
    function automatic logic [7:0] ref_ext(input logic [4:0] imm, input logic z);
        int v;
        v = int'(imm);
        if (!z && v >= 16) v = v + 224;
        return v[7:0];
    endfunction

    // Predicted {req1_ready, req0_ready} for the current inputs.
    function automatic logic [1:0] exp_grant();
        logic can;
        can = (exp_q.size() == 0) || out_ready;
        if (!reset_n || !can) return 2'b00;
        if (req0_valid && req1_valid) begin
`ifdef IMM_EXT_RR_EN
            return m_last ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {req1_valid, req0_valid};
    endfunction

    // Advance one clock: update the model at the edge, return at the next
    // falling edge where new stimulus is driven.
    task automatic tick();
        logic [1:0] g;
        exp_t e;
        g = exp_grant();
        @(posedge clk);
        if (exp_q.size() != 0 && out_ready) begin
            $display("txn consumed id=%0d data=%02h", exp_q[0].id, exp_q[0].d);
            void'(exp_q.pop_front());
        end
        if (g != 2'b00) begin
            e.id = g[1];
            e.d  = g[1] ? ref_ext(req1_imm, req1_zext) : ref_ext(req0_imm, req0_zext);
            exp_q.push_back(e);
            m_last = g[1];
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_imm = '0; req0_zext = 1'b0;
        req1_valid = 1'b0; req1_imm = '0; req1_zext = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_q.delete();
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] g;
        idle_inputs();
        out_ready  = 1'b1;
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({out_valid, out_data, out_id, req1_ready, req0_ready} !== 12'h000)
            $display("FAIL reset_state: got v=%b d=%02h id=%b r1=%b r0=%b required all 0",
                     out_valid, out_data, out_id, req1_ready, req0_ready);
        else passed++;
        exp_q.delete();
        m_last = 1'b1;
        // Release with req0 valid: grant in the first cycle reset is high.
        idle_inputs();
        req0_valid = 1'b1; req0_imm = 5'b10110; req0_zext = 1'b0;
        reset_n    = 1'b1;
        #1;
        g = exp_grant();
        total++;
        if ({req1_ready, req0_ready} !== 2'b01)
            $display("FAIL reset_release_grant: got %b required %b", {req1_ready, req0_ready}, 2'b01);
        else passed++;
        tick();
        idle_inputs();
        out_ready = 1'b0;
        #1;
        total++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 8'hF6})
            $display("FAIL single_sext: got v=%b id=%b d=%02h required v=1 id=0 d=f6",
                     out_valid, out_id, out_data);
        else passed++;
        if (g != 2'b01) $display("FAIL model_grant: got %b required 01", g);
    endtask

    task automatic test_async_reset();
        // Output is FULL with F6 and held; drop reset between clock edges.
        #2;
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, out_id, req1_ready, req0_ready} !== 12'h000)
            $display("FAIL async_reset: got v=%b d=%02h id=%b r1=%b r0=%b required all 0",
                     out_valid, out_data, out_id, req1_ready, req0_ready);
        else passed++;
        exp_q.delete();
        m_last = 1'b1;
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [4:0] imms  [3] = '{5'b10110, 5'b01111, 5'b10000};
        logic       zexts [3] = '{1'b1, 1'b0, 1'b1};
        logic       reqs  [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] want  [3] = '{8'h16, 8'h0F, 8'h10};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (reqs[i]) begin
                req1_valid = 1'b1; req1_imm = imms[i]; req1_zext = zexts[i];
            end else begin
                req0_valid = 1'b1; req0_imm = imms[i]; req0_zext = zexts[i];
            end
            #1;
            total++;
            if ({req1_ready, req0_ready} !== exp_grant())
                $display("FAIL single_ready[%0d]: got %b required %b", i, {req1_ready, req0_ready}, exp_grant());
            else passed++;
            tick();
            idle_inputs();
            #1;
            total++;
            if ({out_valid, out_id, out_data} !== {1'b1, reqs[i], want[i]})
                $display("FAIL single_data[%0d]: got v=%b id=%b d=%02h required v=1 id=%b d=%02h",
                         i, out_valid, out_id, out_data, reqs[i], want[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        apply_reset();
        out_ready  = 1'b1;
        req0_valid = 1'b1; req0_imm = 5'h1F; req0_zext = 1'b0;
        req1_valid = 1'b1; req1_imm = 5'h01; req1_zext = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef IMM_EXT_RR_EN
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            want = 2'b01;
`endif
            total++;
            if ({req1_ready, req0_ready} !== want)
                $display("FAIL contention_grant[%0d]: got %b required %b", i, {req1_ready, req0_ready}, want);
            else passed++;
            if (exp_q.size() != 0) begin
                total++;
                if ({out_valid, out_id, out_data} !== {1'b1, exp_q[0].id, exp_q[0].d})
                    $display("FAIL contention_data[%0d]: got v=%b id=%b d=%02h required v=1 id=%b d=%02h",
                             i, out_valid, out_id, out_data, exp_q[0].id, exp_q[0].d);
                else passed++;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        out_ready  = 1'b1;
        idle_inputs();
        req0_valid = 1'b1; req0_imm = 5'b10110; req0_zext = 1'b0;
        tick();
        idle_inputs();
        out_ready  = 1'b0;
        req1_valid = 1'b1; req1_imm = 5'h05; req1_zext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({req1_ready, req0_ready, out_valid, out_data} !== {2'b00, 1'b1, 8'hF6})
                $display("FAIL backpressure_hold[%0d]: got r=%b v=%b d=%02h required r=00 v=1 d=f6",
                         i, {req1_ready, req0_ready}, out_valid, out_data);
            else passed++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if ({req1_ready, req0_ready} !== 2'b10)
            $display("FAIL backpressure_release: got %b required 10", {req1_ready, req0_ready});
        else passed++;
        tick();
        idle_inputs();
        #1;
        total++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 8'h05})
            $display("FAIL backpressure_next: got v=%b id=%b d=%02h required v=1 id=1 d=05",
                     out_valid, out_id, out_data);
        else passed++;
        tick();
    endtask

    task automatic test_drain();
        logic [1:0] want;
        out_ready = 1'b1;
        idle_inputs();
        req0_valid = 1'b1; req0_imm = 5'h03;
        tick();
        idle_inputs();
        tick();
        #1;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL drain_empty: got out_valid=%b required 0", out_valid);
        else passed++;
        // Requester 0 won last; a contest now goes to requester 1 under RR.
        req0_valid = 1'b1; req0_imm = 5'h02;
        req1_valid = 1'b1; req1_imm = 5'h04;
        #1;
`ifdef IMM_EXT_RR_EN
        want = 2'b10;
`else
        want = 2'b01;
`endif
        total++;
        if ({req1_ready, req0_ready} !== want)
            $display("FAIL drain_last_grant: got %b required %b", {req1_ready, req0_ready}, want);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_sweep();
        logic [1:0] g;
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int z = 0; z < 2; z++) begin
                for (int v = 0; v < 32; v++) begin
                    idle_inputs();
                    if (r == 1) begin
                        req1_valid = 1'b1; req1_imm = v[4:0]; req1_zext = z[0];
                    end else begin
                        req0_valid = 1'b1; req0_imm = v[4:0]; req0_zext = z[0];
                    end
                    #1;
                    g = exp_grant();
                    if ({req1_ready, req0_ready} !== g) begin
                        total++;
                        $display("FAIL sweep_ready r%0d z%0d v%0d: got %b required %b",
                                 r, z, v, {req1_ready, req0_ready}, g);
                    end
                    if (exp_q.size() != 0) begin
                        total++;
                        if ({out_valid, out_id, out_data} !== {1'b1, exp_q[0].id, exp_q[0].d})
                            $display("FAIL sweep_data r%0d z%0d v%0d: got v=%b id=%b d=%02h required v=1 id=%b d=%02h",
                                     r, z, v, out_valid, out_id, out_data, exp_q[0].id, exp_q[0].d);
                        else passed++;
                    end
                    tick();
                end
            end
        end
        idle_inputs();
        #1;
        total++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 8'h1F})
            $display("FAIL sweep_last: got v=%b id=%b d=%02h required v=1 id=1 d=1f",
                     out_valid, out_id, out_data);
        else passed++;
        tick();
        // Explicit boundary: 5'h10 sign-extends to F0 and zero-extends to 10.
        req0_valid = 1'b1; req0_imm = 5'h10; req0_zext = 1'b0;
        tick();
        idle_inputs();
        #1;
        total++;
        if (out_data !== 8'hF0)
            $display("FAIL sweep_boundary_sext: got %02h required f0", out_data);
        else passed++;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_last = 1'b1;
        reset_n   = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_async_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_drain();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
